execute_muldiv_unit: RTL
========================

Name: execute_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the execute stage. It implements the RV64M/RV32M operations, including the W variants.
- Sits beside the ALU. It receives the already-forwarded operands and raises o_busy, which the hazard unit uses to stall fetch/decode/execute.
- It presents a held result that the execute pipeline register captures when the memory stage is not stalled.

Parameters:
- DATA_WIDTH, 64, operand/result width; 32 or 64 only.
- MUL_LATENCY, 2, cycles from accepted start to o_done for multiplies; range 1..4.
- EARLY_OUT, 1, when 1, divide-by-zero and signed overflow finish in 1 cycle.

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  asynchronous reset, active-low.
- i_start  in  1  request; sampled only in IDLE.
- i_func3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_word  in  1  W variant: operate on low 32 bits, sign-extend the 32-bit result. Only valid when DATA_WIDTH=64.
- i_src_1  in  DATA_WIDTH  dividend / multiplicand (rs1).
- i_src_2  in  DATA_WIDTH  divisor / multiplier (rs2).
- i_flush  in  1  branch mispredict / trap kill.
- i_stall_mem  in  1  downstream stall; result must be held.
- o_busy  out  1  request accepted and result not yet consumed.
- o_done  out  1  o_result valid.
- o_result  out  DATA_WIDTH  result.

Behaviour:
- Reset (i_arst low, asynchronous):
  - state=IDLE; o_busy=0, o_done=0, o_result=0.
  - All counters and operand registers are cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - i_start=1 and i_flush=0: latch operands, func3 and word.
  - func3<4 goes to MUL with counter=MUL_LATENCY-1.
  - func3>=4 goes to DIV with counter = (i_word ? 32 : DATA_WIDTH).
  - o_busy rises in the cycle after acceptance.
- MUL:
  - Full 2·DATA_WIDTH product of the sign/zero-extended operands; registered, pipelined or retimed freely.
  - Decrement the counter each cycle; at 0 go to DONE.
  - o_done is first high exactly MUL_LATENCY cycles after the start cycle.
  - Result selection:
    - MUL/MULW: low half.
    - MULH: signed×signed high half.
    - MULHSU: signed×unsigned high half.
    - MULHU: unsigned×unsigned high half.
  - i_word with func3 1..3 is never issued by the decoder; the unit treats it as MULW.
- DIV:
  - Radix-2 restoring division on magnitudes, one quotient bit per cycle. Signs are recorded at acceptance.
  - After N=32/DATA_WIDTH iterations, apply the sign fixup and go to DONE. o_done is first high N+1 cycles after start.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Special cases:
  - Divisor zero: quotient = all ones; remainder = dividend (W: sign-extended low 32).
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
  - With EARLY_OUT=1 both go to DONE after 1 cycle (o_done high 1 cycle after start).
  - With EARLY_OUT=0 they take the full iteration count with identical results.
- DONE:
  - o_done=1, o_busy=1, o_result stable.
  - Leave to IDLE in the first cycle with i_stall_mem=0, at the clock edge that ends that cycle.
  - o_done is therefore high for 1 + (number of stalled cycles) cycles.
  - o_busy is deasserted in the same cycle as o_done falls, so the hazard unit releases the pipeline exactly once.
- i_flush:
  - From any state, next state=IDLE, o_done=0 and o_busy=0 the next cycle.
  - No result is produced and the partial result is discarded.
  - i_flush and i_start in the same IDLE cycle: flush wins, the request is dropped.
- i_start outside IDLE is ignored; operands are not re-latched.
- Width rules:
  - All W results are sign-extended from bit 31.
  - Operands for DIVW/REMW are sign-extended from bit 31; for DIVUW/REMUW they are zero-extended.
- Back-to-back issue: a new start is accepted in the cycle IDLE is re-entered, the cycle after DONE.

Decomposition:
- Package execute_md_pkg holds:
  - enum md_op_t (eight func3 codes);
  - enum md_state_t {IDLE, MUL, DIV, DONE};
  - localparams W_BITS=32 and the DIV_CNT width $clog2(DATA_WIDTH+1).
- One sub-module, div_iter_step: combinational restoring step.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next remainder, next quotient.
  - Instantiated once; the FSM iterates it.

Test Plan:
- MUL 7 × -3, MUL_LATENCY=2 -> o_done first high 2 cycles after start, o_result=0xFFFF_FFFF_FFFF_FFEB. MULHU 0xFFFF_FFFF_FFFF_FFFF squared -> 0xFFFF_FFFF_FFFF_FFFE.
- DIVU 100/7 (DATA_WIDTH=64) -> o_done after 65 cycles, quotient 14. REM -100/7 -> -2 (0xFFFF_FFFF_FFFF_FFFE).
- DIV 5/0 -> o_done 1 cycle after start, result 0xFFFF_FFFF_FFFF_FFFF. REMU 5/0 -> 5. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same -> 0.
- DIVW 0x0000_0001_8000_0000 / 2 -> done after 33 cycles, result 0xFFFF_FFFF_C000_0000. MULW 0x7FFF_FFFF × 2 -> 0xFFFF_FFFF_FFFF_FFFE.
- Flush at cycle 10 of a DIV -> o_busy=0, o_done=0 next cycle. A new start the following cycle completes correctly. Flush+start in the same cycle -> no acceptance.
- i_stall_mem=1 for 3 cycles in DONE -> o_done held 4 cycles with o_result constant, then o_busy/o_done drop together. Asserting i_arst low mid-DIV forces all outputs to 0 immediately.

Source files
------------

// File: rtl/execute_md_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
package execute_md_pkg;

  localparam int W_BITS         = 32;
  localparam int MAX_DATA_WIDTH = 64;
  localparam int DIV_CNT_W      = $clog2(MAX_DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/execute_muldiv_unit_div_iter_step.sv
// One radix-2 restoring division step on unsigned magnitudes:
// shift {rem, quo} left by one, subtract the divisor when it fits.
module div_iter_step
  import execute_md_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] dvs_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, dvs_i};
    // rem_i < dvs_i, so a set top bit of diff can only mean a borrow
    if (diff[DATA_WIDTH]) begin
      rem_o = shifted[DATA_WIDTH-1:0];
      quo_o = {quo_i[DATA_WIDTH-2:0], 1'b0};
    end else begin
      rem_o = diff[DATA_WIDTH-1:0];
      quo_o = {quo_i[DATA_WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Multi-cycle RV64M/RV32M multiply/divide unit beside the ALU; holds its
// result in DONE until the memory stage is free to take it.
module execute_muldiv_unit
  import execute_md_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int MUL_LATENCY = 2,
  parameter bit EARLY_OUT   = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_start,
  input  logic [2:0]            i_func3,
  input  logic                  i_word,
  input  logic [DATA_WIDTH-1:0] i_src_1,
  input  logic [DATA_WIDTH-1:0] i_src_2,
  input  logic                  i_flush,
  input  logic                  i_stall_mem,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int               CNT_W   = DIV_CNT_W;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);

  function automatic logic [DATA_WIDTH-1:0] sext32(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] r;
    r = x;
    for (int i = W_BITS; i < DATA_WIDTH; i++) r[i] = x[W_BITS-1];
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zext32(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] r;
    r = x;
    for (int i = W_BITS; i < DATA_WIDTH; i++) r[i] = 1'b0;
    return r;
  endfunction

  md_state_t             state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q, done_q;
  logic [DATA_WIDTH-1:0] result_q;
  md_op_t                func_q;
  logic                  word_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q, spec_q;
  logic                  qneg_q, rneg_q, special_q;

  // Request decode and divide set-up from the live inputs (used on acceptance)
  md_op_t                op_in;
  logic                  word_in, sgn_in, neg_a, neg_b, zero_in, ovf_in;
  logic [DATA_WIDTH-1:0] a_x, b_x, mag_a, mag_b, min_x, spec_d, quo_init_d;

  always_comb begin
    op_in   = md_op_t'(i_func3);
    word_in = i_word && (DATA_WIDTH == 64);
    sgn_in  = !i_func3[0];
    a_x     = word_in ? (sgn_in ? sext32(i_src_1) : zext32(i_src_1)) : i_src_1;
    b_x     = word_in ? (sgn_in ? sext32(i_src_2) : zext32(i_src_2)) : i_src_2;
    neg_a   = sgn_in && a_x[DATA_WIDTH-1];
    neg_b   = sgn_in && b_x[DATA_WIDTH-1];
    mag_a   = neg_a ? -a_x : a_x;
    mag_b   = neg_b ? -b_x : b_x;
    min_x   = '0;
    if (word_in) begin
      for (int i = W_BITS - 1; i < DATA_WIDTH; i++) min_x[i] = 1'b1;
    end else begin
      min_x[DATA_WIDTH-1] = 1'b1;
    end
    zero_in = (b_x == '0);
    ovf_in  = sgn_in && (a_x == min_x) && (b_x == '1);
    if (zero_in) begin
      spec_d = i_func3[1] ? (word_in ? sext32(i_src_1) : i_src_1) : '1;
    end else begin
      spec_d = i_func3[1] ? '0 : a_x;
    end
    // W dividends sit in the top half so 32 shifts bring every bit through
    quo_init_d = word_in ? (mag_a << W_BITS) : mag_a;
  end

  // Multiplier reads live inputs in IDLE so a single-cycle latency still works
  md_op_t                  m_op;
  logic                    m_word, m_a_sgn, m_b_sgn;
  logic [DATA_WIDTH-1:0]   m_a, m_b, mul_res_d;
  logic [2*DATA_WIDTH-1:0] ea, eb, prod;

  always_comb begin
    m_op    = (state_q == IDLE) ? op_in   : func_q;
    m_word  = (state_q == IDLE) ? word_in : word_q;
    m_a     = (state_q == IDLE) ? i_src_1 : a_q;
    m_b     = (state_q == IDLE) ? i_src_2 : b_q;
    m_a_sgn = (m_op == OP_MULH) || (m_op == OP_MULHSU);
    m_b_sgn = (m_op == OP_MULH);
    ea      = {{DATA_WIDTH{m_a_sgn && m_a[DATA_WIDTH-1]}}, m_a};
    eb      = {{DATA_WIDTH{m_b_sgn && m_b[DATA_WIDTH-1]}}, m_b};
    prod    = ea * eb;
    if (m_word) begin
      mul_res_d = sext32(prod[DATA_WIDTH-1:0]);
    end else if (m_op == OP_MUL) begin
      mul_res_d = prod[DATA_WIDTH-1:0];
    end else begin
      mul_res_d = prod[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  logic [DATA_WIDTH-1:0] rem_n, quo_n, qv, rv, dv, div_res_d;

  div_iter_step #(.DATA_WIDTH(DATA_WIDTH)) u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_n),
    .quo_o (quo_n)
  );

  always_comb begin
    qv        = qneg_q ? -quo_n : quo_n;
    rv        = rneg_q ? -rem_n : rem_n;
    dv        = ((func_q == OP_REM) || (func_q == OP_REMU)) ? rv : qv;
    div_res_d = special_q ? spec_q : (word_q ? sext32(dv) : dv);
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      func_q    <= OP_MUL;
      word_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      spec_q    <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      special_q <= 1'b0;
    end else if (i_flush) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            func_q    <= op_in;
            word_q    <= word_in;
            a_q       <= i_src_1;
            b_q       <= i_src_2;
            rem_q     <= '0;
            quo_q     <= quo_init_d;
            dvs_q     <= mag_b;
            qneg_q    <= neg_a ^ neg_b;
            rneg_q    <= neg_a;
            special_q <= zero_in || ovf_in;
            spec_q    <= spec_d;
            busy_q    <= 1'b1;
            if (!i_func3[2]) begin
              if (MUL_LATENCY == 1) begin
                state_q  <= DONE;
                done_q   <= 1'b1;
                result_q <= mul_res_d;
              end else begin
                state_q <= MUL;
                cnt_q   <= MUL_CNT;
              end
            end else if (EARLY_OUT && (zero_in || ovf_in)) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= spec_d;
            end else begin
              state_q <= DIV;
              cnt_q   <= word_in ? CNT_W'(W_BITS) : CNT_W'(DATA_WIDTH);
            end
          end
        end
        MUL: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= mul_res_d;
          end
        end
        DIV: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= div_res_d;
          end
        end
        DONE: begin
          if (!i_stall_mem) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;

endmodule
